// File: rtl/cpu_common_pkg.sv
// Shared CPU-wide constants and the write-back source numbering.
package cpu_common;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned NUM_REGS   = 8;

    // Source slot assignment used by the core when wiring write-back producers.
    typedef enum logic [1:0] {
        WB_SRC_IMM = 2'd0,
        WB_SRC_R0  = 2'd1,
        WB_SRC_ALU = 2'd2,
        WB_SRC_MEM = 2'd3
    } wb_src_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr_i (wrapping) wins.
// The winner index is reported even when disabled; the grant is gated by en_i.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o
);

    logic          found;
    logic [PW-1:0] cand;

    // Scan from the pointer, keep the first request seen.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = PW'((32'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        if (en_i && found) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file write-back arbiter: round-robin grant into a single-entry
// write buffer that drives the RF write port and a forwarding probe.
module rf_wb_arb #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = cpu_common::DATA_WIDTH,
    parameter int unsigned NUM_REGS   = cpu_common::NUM_REGS,
    localparam int unsigned RA_WIDTH  = $clog2(NUM_REGS),
    localparam int unsigned PW        = $clog2(NUM_SRC)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data,
    input  logic [NUM_SRC*RA_WIDTH-1:0]    src_rd,
    input  logic                           wb_stall,
    output logic                           rf_we,
    output logic [RA_WIDTH-1:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0]          rf_wdata,
    input  logic [RA_WIDTH-1:0]            fwd_rd,
    output logic                           fwd_hit,
    output logic [DATA_WIDTH-1:0]          fwd_data
);

    logic                  buf_valid_q, buf_valid_d;
    logic [RA_WIDTH-1:0]   buf_rd_q, buf_rd_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;

    logic                  can_accept;
    logic                  fire;
    logic [PW-1:0]         win_idx;
    logic [RA_WIDTH-1:0]   win_rd;
    logic [DATA_WIDTH-1:0] win_data;

    // Buffer is empty or retiring this cycle, so a new write fits.
    assign can_accept = !buf_valid_q || !wb_stall;

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_arb (
        .req_i (src_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (can_accept),
        .gnt_o (src_ready),
        .idx_o (win_idx)
    );

    assign fire = |(src_valid & src_ready);

    // One-hot mux of the granted source's payload.
    always_comb begin
        win_rd   = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_ready[i]) begin
                win_rd   = src_rd[i*RA_WIDTH +: RA_WIDTH];
                win_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rf_we    = buf_valid_q && !wb_stall;
    assign rf_waddr = buf_rd_q;
    assign rf_wdata = buf_data_q;

    assign fwd_hit  = buf_valid_q && (buf_rd_q == fwd_rd);
    assign fwd_data = buf_data_q;

    // Next state: load on handshake, otherwise empty the buffer when it drains.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (fire) begin
            buf_valid_d = 1'b1;
            buf_rd_d    = win_rd;
            buf_data_d  = win_data;
            rr_ptr_d    = (32'(win_idx) == NUM_SRC - 1) ? '0 : win_idx + PW'(1);
        end else if (rf_we) begin
            buf_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; a pending write is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_rd_q    <= '0;
            buf_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_rd_q    <= buf_rd_d;
            buf_data_q  <= buf_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb: scenario tasks plus a write scoreboard.
module tb_rf_wb_arb;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned RW = 3;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic             clk;
    logic             rst;
    logic [NS-1:0]    src_valid;
    logic [NS-1:0]    src_ready;
    logic [NS*DW-1:0] src_data;
    logic [NS*RW-1:0] src_rd;
    logic             wb_stall;
    logic             rf_we;
    logic [RW-1:0]    rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic [RW-1:0]    fwd_rd;
    logic             fwd_hit;
    logic [DW-1:0]    fwd_data;

    int  n_checks;
    int  n_errors;
    wr_t exp_q[$];

    rf_wb_arb #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .NUM_REGS   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_data  (src_data),
        .src_rd    (src_rd),
        .wb_stall  (wb_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .fwd_rd    (fwd_rd),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every RF write must match the oldest expected one.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            wr_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_write: got waddr=%0d wdata=%h, required no write",
                         rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if (rf_waddr !== e.rd || rf_wdata !== e.data) begin
                    n_errors++;
                    $display("FAIL sb_write: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                             rf_waddr, rf_wdata, e.rd, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [RW-1:0] rd, input logic [DW-1:0] d);
        src_rd[i*RW +: RW]   = rd;
        src_data[i*DW +: DW] = d;
    endtask

    task automatic push_exp(input logic [RW-1:0] rd, input logic [DW-1:0] d);
        wr_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data} !== '0 || src_ready !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_outputs: got we=%b waddr=%0d wdata=%h hit=%b fdata=%h ready=%b, required all 0",
                     rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, src_ready);
        end
        src_valid = 4'b0100;
        #1;
        n_checks++;
        if (src_ready !== 4'b0100) begin
            n_errors++;
            $display("FAIL reset_ready_follows: got %b, required 0100", src_ready);
        end
        // Withdraw before the edge: no write must result.
        src_valid = 4'b0000;
        step();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_dropped_req: got rf_we=%b, required 0", rf_we);
        end
    endtask

    task automatic test_round_robin();
        logic [NS-1:0] exp_rdy;
        for (int i = 0; i < 4; i++) set_src(i, RW'(i + 1), DW'(8'h10 + i));
        src_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            exp_rdy = 4'b0001 << (c % 4);
            n_checks++;
            if (src_ready !== exp_rdy) begin
                n_errors++;
                $display("FAIL rr_grant_c%0d: got %b, required %b", c, src_ready, exp_rdy);
            end
            if (c > 0) begin
                n_checks++;
                if (rf_we !== 1'b1 || rf_wdata !== DW'(8'h10 + (c - 1) % 4)) begin
                    n_errors++;
                    $display("FAIL rr_retire_c%0d: got we=%b wdata=%h, required we=1 wdata=%h",
                             c, rf_we, rf_wdata, DW'(8'h10 + (c - 1) % 4));
                end
            end
            push_exp(RW'(c % 4 + 1), DW'(8'h10 + c % 4));
            step();
        end
        src_valid = 4'b0000;
        #1;
        n_checks++;
        if (rf_we !== 1'b1 || rf_wdata !== 8'h10 || rf_waddr !== 3'd1) begin
            n_errors++;
            $display("FAIL rr_wrap_retire: got we=%b waddr=%0d wdata=%h, required we=1 waddr=1 wdata=10",
                     rf_we, rf_waddr, rf_wdata);
        end
        step();
    endtask

    task automatic test_single_alu();
        set_src(2, 3'd3, 8'hA5);
        src_valid = 4'b0100;
        #1;
        n_checks++;
        if (src_ready !== 4'b0100) begin
            n_errors++;
            $display("FAIL alu_ready: got %b, required 0100", src_ready);
        end
        push_exp(3'd3, 8'hA5);
        step();
        src_valid = 4'b0000;
        #1;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 8'hA5) begin
            n_errors++;
            $display("FAIL alu_write: got we=%b waddr=%0d wdata=%h, required we=1 waddr=3 wdata=a5",
                     rf_we, rf_waddr, rf_wdata);
        end
        step();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_errors++;
            $display("FAIL alu_single_pulse: got rf_we=%b, required 0", rf_we);
        end
    endtask

    task automatic test_stall();
        set_src(0, 3'd5, 8'h3C);
        src_valid = 4'b0001;
        push_exp(3'd5, 8'h3C);
        step();
        set_src(1, 3'd6, 8'h5A);
        src_valid = 4'b0010;
        wb_stall  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (rf_we !== 1'b0 || src_ready !== 4'b0000) begin
                n_errors++;
                $display("FAIL stall_c%0d: got we=%b ready=%b, required we=0 ready=0000",
                         k, rf_we, src_ready);
            end
            step();
        end
        wb_stall = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd5 || rf_wdata !== 8'h3C || src_ready !== 4'b0010) begin
            n_errors++;
            $display("FAIL stall_release: got we=%b waddr=%0d wdata=%h ready=%b, required 1 5 3c 0010",
                     rf_we, rf_waddr, rf_wdata, src_ready);
        end
        push_exp(3'd6, 8'h5A);
        step();
        src_valid = 4'b0000;
        #1;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd6 || rf_wdata !== 8'h5A) begin
            n_errors++;
            $display("FAIL stall_next_write: got we=%b waddr=%0d wdata=%h, required 1 6 5a",
                     rf_we, rf_waddr, rf_wdata);
        end
        step();
    endtask

    task automatic test_forwarding();
        set_src(2, 3'd2, 8'h77);
        src_valid = 4'b0100;
        push_exp(3'd2, 8'h77);
        step();
        src_valid = 4'b0000;
        wb_stall  = 1'b1;
        fwd_rd    = 3'd2;
        #1;
        n_checks++;
        if (fwd_hit !== 1'b1 || fwd_data !== 8'h77) begin
            n_errors++;
            $display("FAIL fwd_hit: got hit=%b data=%h, required hit=1 data=77", fwd_hit, fwd_data);
        end
        fwd_rd = 3'd6;
        #1;
        n_checks++;
        if (fwd_hit !== 1'b0) begin
            n_errors++;
            $display("FAIL fwd_miss: got hit=%b, required 0", fwd_hit);
        end
        wb_stall = 1'b0;
        step();
        fwd_rd = 3'd2;
        #1;
        n_checks++;
        if (fwd_hit !== 1'b0) begin
            n_errors++;
            $display("FAIL fwd_after_retire: got hit=%b, required 0", fwd_hit);
        end
    endtask

    task automatic test_reset_mid();
        set_src(1, 3'd4, 8'h99);
        src_valid = 4'b0010;
        step();
        // This buffered write must be discarded by the reset.
        src_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_src(i, RW'(7 - i), DW'(8'hC0 + i));
        wb_stall = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        wb_stall = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || src_ready !== 4'b0001) begin
            n_errors++;
            $display("FAIL rst_mid: got we=%b ready=%b, required we=0 ready=0001", rf_we, src_ready);
        end
        push_exp(3'd7, 8'hC0);
        step();
        src_valid = 4'b0000;
        step();
        step();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_idle: got rf_we=%b, required 0", rf_we);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        src_valid = '0;
        src_data  = '0;
        src_rd    = '0;
        wb_stall  = 1'b0;
        fwd_rd    = '0;

        test_reset();
        test_round_robin();
        test_single_alu();
        test_stall();
        test_forwarding();
        test_reset_mid();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drained: got %0d writes outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
